// File: rtl/traffic_req_conditioner.sv
// Conditions the NS pedestrian button and EW vehicle loop for the traffic light controller:
// synchronize, debounce, latch and age requests until served, and generate the phase tick.
module traffic_req_conditioner #(
  parameter int CLK_HZ    = 2080000,
  parameter int TICK_HZ   = 1,
  parameter int DB_CYCLES = 20800,
  parameter int AGE_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_ns_n,
  input  logic             btn_ew_n,
  input  logic [1:0]       ns_light,
  input  logic [1:0]       ew_light,
  output logic             tick,
  output logic             req_ns,
  output logic             req_ew,
  output logic [AGE_W-1:0] age_ns,
  output logic [AGE_W-1:0] age_ew
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [1:0]       GREEN   = 2'b01;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic {IDLE, PENDING} req_state_t;

  logic [PW-1:0]    pre_cnt;
  logic [1:0]       btn_raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       db_val;
  logic [1:0]       db_prev;
  logic [1:0]       press;
  logic [DBW-1:0]   db_cnt     [2];
  logic [1:0]       light      [2];
  req_state_t       state      [2];
  req_state_t       state_next [2];
  logic [AGE_W-1:0] age        [2];

  // Index 0 is the NS direction, index 1 is EW.
  assign btn_raw  = {btn_ew_n, btn_ns_n};
  assign light[0] = ns_light;
  assign light[1] = ew_light;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PW'(DIV - 1)) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  assign tick = (pre_cnt == PW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // The counter holds at DB_CYCLES for one cycle before the flip, which gives the
  // one-cycle debounce-to-latch stage in the overall press latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_val  <= 2'b11;
      db_prev <= 2'b11;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      db_prev <= db_val;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_val[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DB_CYCLES)) begin
          db_val[i] <= ~db_val[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  assign press = db_prev & ~db_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) state[i] <= IDLE;
    end else begin
      for (int i = 0; i < 2; i++) state[i] <= state_next[i];
    end
  end

  always_comb begin
    state_next = state;
    for (int i = 0; i < 2; i++) begin
      case (state[i])
        IDLE:    if (press[i] && light[i] != GREEN) state_next[i] = PENDING;
        PENDING: if (light[i] == GREEN) state_next[i] = IDLE;
        default: state_next[i] = IDLE;
      endcase
    end
  end

  // Ticks only count once the request was already pending before this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (state_next[i] == IDLE) begin
          age[i] <= '0;
        end else if (state[i] == PENDING && tick && age[i] != AGE_MAX) begin
          age[i] <= age[i] + AGE_W'(1);
        end
      end
    end
  end

  assign req_ns = (state[0] == PENDING);
  assign req_ew = (state[1] == PENDING);
  assign age_ns = age[0];
  assign age_ew = age[1];

endmodule

// File: tb/tb_traffic_req_conditioner.sv
// Bench for traffic_req_conditioner: directed vector table, hand-written corner sequences,
// and randomized stimulus compared against an edge-level behavioural model.
module tb_traffic_req_conditioner;

  localparam int CLK_HZ  = 100;
  localparam int TICK_HZ = 10;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int DB      = 4;
  localparam int AGE_W   = 4;
  localparam int AGE_MAX = (1 << AGE_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             btn_ns_n = 1'b1;
  logic             btn_ew_n = 1'b1;
  logic [1:0]       ns_light = 2'b00;
  logic [1:0]       ew_light = 2'b00;
  logic             tick;
  logic             req_ns;
  logic             req_ew;
  logic [AGE_W-1:0] age_ns;
  logic [AGE_W-1:0] age_ew;

  int checks = 0;
  int errors = 0;

  traffic_req_conditioner #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DB_CYCLES(DB), .AGE_W(AGE_W)
  ) dut (
    .clk(clk), .reset(reset), .btn_ns_n(btn_ns_n), .btn_ew_n(btn_ew_n),
    .ns_light(ns_light), .ew_light(ew_light), .tick(tick),
    .req_ns(req_ns), .req_ew(req_ew), .age_ns(age_ns), .age_ew(age_ew)
  );

  always #5 clk = ~clk;

  // Reference model: m_n counts edges since reset release; a level is accepted once the
  // synchronized input has differed from the accepted level for DB consecutive edges
  // after the first differing one; the press acts on the request one edge later.
  int         m_n;
  logic [1:0] m_line [2];
  logic       m_db [2];
  int         m_since [2];
  logic       m_press [2];
  logic       m_req [2];
  int         m_age [2];

  function automatic logic m_tick();
    return (m_n % DIV) == DIV - 1;
  endfunction

  task automatic model_reset();
    m_n = 0;
    for (int d = 0; d < 2; d++) begin
      m_line[d] = 2'b11; m_db[d] = 1'b1; m_since[d] = -1;
      m_press[d] = 1'b0; m_req[d] = 1'b0; m_age[d] = 0;
    end
  endtask

  task automatic model_step();
    logic       tick_now;
    logic       raw;
    logic       samp;
    logic [1:0] l;
    int         e;
    tick_now = m_tick();
    e = m_n + 1;
    for (int d = 0; d < 2; d++) begin
      raw = (d == 0) ? btn_ns_n : btn_ew_n;
      l   = (d == 0) ? ns_light : ew_light;
      if (!m_req[d]) begin
        if (m_press[d] && l != 2'b01) begin m_req[d] = 1'b1; m_age[d] = 0; end
      end else if (l == 2'b01) begin
        m_req[d] = 1'b0; m_age[d] = 0;
      end else if (tick_now && m_age[d] < AGE_MAX) begin
        m_age[d]++;
      end
      m_press[d] = 1'b0;
      samp = m_line[d][1];
      m_line[d] = {m_line[d][0], raw};
      if (samp == m_db[d]) begin
        m_since[d] = -1;
      end else begin
        if (m_since[d] < 0) m_since[d] = e;
        if (e - m_since[d] == DB) begin
          m_db[d] = ~m_db[d];
          m_since[d] = -1;
          if (m_db[d] == 1'b0) m_press[d] = 1'b1;
        end
      end
    end
    m_n++;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  task automatic applyStimulus(input logic bns, input logic bew,
                               input logic [1:0] nl, input logic [1:0] el);
    btn_ns_n = bns; btn_ew_n = bew; ns_light = nl; ew_light = el;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic et, input logic ens,
                             input logic eew, input logic [AGE_W-1:0] ans,
                             input logic [AGE_W-1:0] aew);
    checks++;
    if ({tick, req_ns, req_ew, age_ns, age_ew} !== {et, ens, eew, ans, aew}) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got tick=%0b req_ns=%0b req_ew=%0b age_ns=%0d age_ew=%0d, expected tick=%0b req_ns=%0b req_ew=%0b age_ns=%0d age_ew=%0d",
               name, $time, tick, req_ns, req_ew, age_ns, age_ew, et, ens, eew, ans, aew);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, m_tick(), m_req[0], m_req[1], AGE_W'(m_age[0]), AGE_W'(m_age[1]));
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b00, 2'b00);
    run(2);
    checkOutput("reset_state", 1'b0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
  endtask

  typedef struct {
    logic       bns;
    logic       bew;
    logic [1:0] nl;
    logic [1:0] el;
    int         cycles;
    logic       et;
    logic       ens;
    logic       eew;
    logic [3:0] ans;
    logic [3:0] aew;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic       bns;
    logic       bew;
    logic [1:0] nl;
    logic [1:0] el;

    // Cumulative timeline from reset release; comments give edges since release.
    vecs[0]  = '{1'b1, 1'b1, 2'b00, 2'b00,  5, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}; // 5
    vecs[1]  = '{1'b0, 1'b1, 2'b00, 2'b00,  7, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}; // 12
    vecs[2]  = '{1'b0, 1'b1, 2'b00, 2'b00,  1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0}; // 13
    vecs[3]  = '{1'b1, 1'b1, 2'b00, 2'b00,  7, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0}; // 20
    vecs[4]  = '{1'b1, 1'b1, 2'b00, 2'b00, 10, 1'b0, 1'b1, 1'b0, 4'd2, 4'd0}; // 30
    vecs[5]  = '{1'b1, 1'b1, 2'b01, 2'b00,  1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}; // 31
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 2'b00,  3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}; // 34
    vecs[7]  = '{1'b1, 1'b1, 2'b00, 2'b00,  2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}; // 36
    vecs[8]  = '{1'b1, 1'b0, 2'b00, 2'b00,  3, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0}; // 39
    vecs[9]  = '{1'b1, 1'b1, 2'b00, 2'b00, 10, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0}; // 49
    vecs[10] = '{1'b1, 1'b0, 2'b00, 2'b00, 10, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0}; // 59
    vecs[11] = '{1'b1, 1'b1, 2'b00, 2'b00,  1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1}; // 60
    vecs[12] = '{1'b1, 1'b1, 2'b00, 2'b01,  1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}; // 61

    $display("[TB] reset and prescaler");
    doReset();
    for (int n = 0; n <= 30; n++) begin
      checkOutput($sformatf("prescaler_n%0d", n), (n % DIV) == DIV - 1, 1'b0, 1'b0, '0, '0);
      run(1);
    end

    $display("[TB] vector table");
    doReset();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].bns, vecs[i].bew, vecs[i].nl, vecs[i].el);
      run(vecs[i].cycles);
      checkOutput($sformatf("vector_%0d", i), vecs[i].et, vecs[i].ens, vecs[i].eew,
                  vecs[i].ans, vecs[i].aew);
    end

    $display("[TB] service clear and press during green");
    doReset();
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b00);
    run(7);
    checkOutput("svc_before_latch", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    run(1);
    checkOutput("svc_latched", 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    run(44);
    checkOutput("svc_age5", 1'b0, 1'b1, 1'b0, 4'd5, 4'd0);
    applyStimulus(1'b1, 1'b1, 2'b01, 2'b00);
    run(1);
    checkOutput("svc_cleared", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    run(8);
    applyStimulus(1'b0, 1'b1, 2'b01, 2'b00);
    run(10);
    checkOutput("svc_press_in_green", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b00);
    run(3);
    checkOutput("svc_green_press_dropped", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    $display("[TB] saturation, simultaneous presses, reset mid-operation");
    doReset();
    applyStimulus(1'b0, 1'b0, 2'b10, 2'b10);
    run(7);
    checkOutput("sat_before_latch", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    run(1);
    checkOutput("sat_both_latched", 1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
    run(197);
    checkOutput("sat_after_20_ticks", 1'b0, 1'b1, 1'b1, 4'd15, 4'd15);
    run(50);
    checkOutput("sat_holds", 1'b0, 1'b1, 1'b1, 4'd15, 4'd15);
    applyStimulus(1'b1, 1'b1, 2'b10, 2'b10);
    run(10);
    checkOutput("mid_still_pending", 1'b0, 1'b1, 1'b1, 4'd15, 4'd15);
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_immediate", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    reset = 1'b1;
    run(20);
    checkOutput("mid_no_reassert", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    $display("[TB] randomized against model");
    doReset();
    bns = 1'b1; bew = 1'b1; nl = 2'b00; el = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      checkModel("random");
      if ($urandom_range(0, 5) == 0) bns = ~bns;
      if ($urandom_range(0, 5) == 0) bew = ~bew;
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 19) == 0) begin
          int r;
          logic [1:0] pick;
          r = $urandom_range(0, 9);
          pick = (r < 6) ? 2'b00 : (r < 8) ? 2'b10 : (r == 8) ? 2'b01 : 2'b11;
          if (d == 0) nl = pick; else el = pick;
        end
      end
      applyStimulus(bns, bew, nl, el);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 799) == 0) reset = 1'b0;
      run(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_req_conditioner.md
# traffic_req_conditioner

Input conditioning stage that sits directly upstream of the traffic light controller, in the same clock domain. It synchronizes and debounces the NS pedestrian pushbutton and the EW vehicle-loop sensor. Each accepted press is latched as a pending request, held until the controller's light outputs show that direction served, and aged in seconds. The block also generates the 1 Hz phase tick so the controller's timers count seconds rather than raw oscillator cycles.

## Interface
- CLK_HZ, 2080000: frequency of `clk` in Hz (internal OSCH, 2.08 MHz).
- TICK_HZ, 1: tick rate. DIV = CLK_HZ/TICK_HZ, must be ≥ 2.
- DB_CYCLES, 20800: consecutive stable cycles needed to accept a level change (10 ms). Must be ≥ 1.
- AGE_W, 8: width of each request age counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset. Asserting it clears all state immediately; deassertion is synchronous to `clk`.
- btn_ns_n  in  1  raw NS pedestrian button, active-low, asynchronous to `clk`
- btn_ew_n  in  1  raw EW vehicle sensor, active-low, asynchronous to `clk`
- ns_light  in  2  controller NS light code: 00 red, 01 green, 10 yellow, 11 invalid
- ew_light  in  2  controller EW light code, same encoding
- tick  out  1  one-cycle pulse, once every DIV cycles
- req_ns  out  1  NS request pending
- req_ew  out  1  EW request pending
- age_ns  out  AGE_W  ticks elapsed while req_ns is pending, saturating
- age_ew  out  AGE_W  ticks elapsed while req_ew is pending, saturating

## Operation
- **Synchronizer:** two flops per button, reset value 1 (released).
- **Debouncer:** one counter per input.
  - Counter clears whenever the synchronized value equals the debounced value.
  - Otherwise it increments. When it reaches DB_CYCLES, the debounced value flips and the counter clears.
  - Debounced reset value is 1.
- **Press event:** debounced 1→0 transition gives a one-cycle internal pulse. A release (0→1) produces nothing.
- **Request latch:** one FSM per direction, states IDLE and PENDING.
  - IDLE → PENDING on a press event, unless that direction's light is 01 (green) in the same cycle. A press during green is dropped.
  - PENDING → IDLE when that direction's light is 01.
  - Further presses while PENDING have no effect.
  - Codes 00, 10 and 11 never serve a request.
- **Age counter:**
  - Clears on entry to IDLE.
  - While PENDING, increments on each `tick` and saturates at 2^AGE_W−1.
  - A tick in the cycle the request is set does not count; age starts at 0.
- **Prescaler:** counter runs 0..DIV−1 and wraps to 0. `tick` = 1 when the counter equals DIV−1. It runs freely and is independent of all inputs.
- The two directions are fully independent. Simultaneous presses on both set both requests in the same cycle.

## Timing
- **Reset values:** tick=0, req_ns=req_ew=0, age_ns=age_ew=0. Prescaler, debouncer and synchronizer state return to idle/released.
- **Reset mid-operation:**
  - Pending requests are lost.
  - A button held through reset deassertion is accepted as a fresh press after the normal latency.
- **First tick:** `tick` first pulses in the DIV-th cycle after reset deassertion, then every DIV cycles.
- **Press latency:** button low first sampled at edge k gives req high after edge k+DB_CYCLES+3 (2 sync, DB_CYCLES debounce, 1 latch).
- **Bounce:** any glitch shorter than DB_CYCLES cycles after synchronization never reaches the latch.
- **Service latency:** light = 01 sampled at edge k gives req low and age = 0 after edge k. The light inputs are registered in the same domain, so no synchronizer is needed on them.
- **Simultaneous events:**
  - Press and green in the same cycle: request stays 0.
  - Tick and service in the same cycle: age clears; the tick is not counted.

## Test plan
Bench parameters: CLK_HZ=100, TICK_HZ=10 (DIV=10), DB_CYCLES=4, AGE_W=4.
- **Reset and prescaler:** hold reset=0, then release. Required: all outputs 0; tick pulses on the 10th, 20th and 30th cycles after release, each exactly 1 cycle wide.
- **Clean press:** btn_ns_n low from edge k with ns_light=00. Required: req_ns rises after edge k+7; req_ew stays 0; age_ns counts 1, 2, 3… on each subsequent tick.
- **Bounce rejection:** btn_ew_n pulses low for 3 cycles, high for 2, low for 3, then stays high. Required: req_ew never asserts. The same input held low for 8 cycles does set req_ew.
- **Service clear:** with req_ns pending and age_ns=5, drive ns_light=01. Required: req_ns=0 and age_ns=0 on the next edge. A press during that green leaves req_ns at 0.
- **Saturation and simultaneous presses:** both buttons pressed together with both lights at 10. Required: req_ns and req_ew rise in the same cycle; after 20 ticks both ages read 15 and hold at 15.
- **Reset mid-operation:** with both requests pending, pulse reset low for 1 cycle. Required: requests and ages drop to 0 immediately. With buttons released, the requests do not reassert.
